// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate generator behind a one-cycle registered valid/ready stage.
// M drives the outputs; K is a skid entry so in_ready never depends on out_ready.
module imm_extend_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef enum logic [1:0] {
    StEmpty   = 2'b00,
    StInvalid = 2'b01,
    StOne     = 2'b10,
    StFull    = 2'b11
  } state_e;

  logic             m_valid, k_valid, m_valid_d, k_valid_d;
  logic [XLEN-1:0]  m_imm, k_imm;
  logic [TAG_W-1:0] m_tag, k_tag;
  logic             m_ill, k_ill;
  logic             m_load_in, m_load_k, k_load;
  logic             in_fire, out_fire;
  state_e           state;

  logic [31:0]      sx32;
  logic             sx_en;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_ill;

  always_comb begin
    sx32    = '0;
    sx_en   = 1'b1;
    dec_imm = '0;
    dec_ill = 1'b0;
    case (in_immsrc)
      3'b000: sx32 = {{20{in_instr[31]}}, in_instr[31:20]};
      3'b001: sx32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      3'b010: sx32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                      in_instr[11:8], 1'b0};
      3'b011: sx32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};
      3'b100: sx32 = {in_instr[31:12], 12'b0};
      3'b101: begin
        sx_en        = 1'b0;
        dec_imm[4:0] = in_instr[19:15];
      end
      3'b110: begin
        sx_en = 1'b0;
        if (XLEN == 64) begin
          dec_imm[5:0] = in_instr[25:20];
        end else begin
          // RV32 shift amounts are 5 bits; bit 25 set is not a legal encoding
          dec_imm[4:0] = in_instr[24:20];
          dec_ill      = in_instr[25];
        end
      end
      default: begin
        sx_en   = 1'b0;
        dec_ill = 1'b1;
      end
    endcase
    if (sx_en) begin
      dec_imm       = {XLEN{sx32[31]}};
      dec_imm[31:0] = sx32;
    end
  end

  assign in_ready = ~k_valid;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid & out_ready;
  assign state    = state_e'({m_valid, k_valid});

  always_comb begin
    m_valid_d = m_valid;
    k_valid_d = k_valid;
    m_load_in = 1'b0;
    m_load_k  = 1'b0;
    k_load    = 1'b0;
    if (flush) begin
      m_valid_d = 1'b0;
      k_valid_d = 1'b0;
    end else begin
      case (state)
        StEmpty: begin
          if (in_fire) begin
            m_load_in = 1'b1;
            m_valid_d = 1'b1;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            m_load_in = 1'b1;
          end else if (in_fire) begin
            k_load    = 1'b1;
            k_valid_d = 1'b1;
          end else if (out_fire) begin
            m_valid_d = 1'b0;
          end
        end
        StFull: begin
          if (out_fire) begin
            m_load_k  = 1'b1;
            k_valid_d = 1'b0;
          end
        end
        default: begin
          m_valid_d = 1'b0;
          k_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
      m_imm   <= '0;
      m_tag   <= '0;
      m_ill   <= 1'b0;
      k_imm   <= '0;
      k_tag   <= '0;
      k_ill   <= 1'b0;
    end else begin
      m_valid <= m_valid_d;
      k_valid <= k_valid_d;
      if (m_load_in) begin
        m_imm <= dec_imm;
        m_tag <= in_tag;
        m_ill <= dec_ill;
      end else if (m_load_k) begin
        m_imm <= k_imm;
        m_tag <= k_tag;
        m_ill <= k_ill;
      end
      if (k_load) begin
        k_imm <= dec_imm;
        k_tag <= in_tag;
        k_ill <= dec_ill;
      end
    end
  end

  assign out_valid   = m_valid;
  assign out_imm     = m_imm;
  assign out_tag     = m_tag;
  assign out_illegal = m_ill;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed and randomised checks of imm_extend_pipe, with XLEN=32 and XLEN=64 instances
// sharing one input stream.
module tb_imm_extend_pipe;
  localparam int unsigned TW = 5;
  localparam int N_BEATS = 10000;
  localparam int CYC_LIMIT = 40000;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0] in_immsrc = '0;
  logic [TW-1:0] in_tag = '0;
  logic rdy32, rdy64, ov32, ov64, il32, il64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [TW-1:0] tag32, tag64;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] i32;
    logic l32;
    logic [63:0] i64;
    logic l64;
    logic [TW-1:0] tag;
  } exp_t;

  logic [31:0] v_instr [8] = '{32'hFFF00093, 32'h00A12423, 32'hFE000EE3, 32'h0080006F,
                               32'h800000B7, 32'h000FD073, 32'h03F01013, 32'h12345678};
  logic [31:0] v_e32 [8] = '{32'hFFFFFFFF, 32'h8, 32'hFFFFFFFC, 32'h8, 32'h80000000,
                             32'h1F, 32'h1F, 32'h0};
  logic [63:0] v_e64 [8] = '{64'hFFFFFFFFFFFFFFFF, 64'h8, 64'hFFFFFFFFFFFFFFFC, 64'h8,
                             64'hFFFFFFFF80000000, 64'h1F, 64'h3F, 64'h0};
  logic v_i32 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic v_i64 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  imm_extend_pipe #(.XLEN(32), .TAG_W(TW)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag), .out_valid(ov32),
    .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_illegal(il32)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(TW)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag), .out_valid(ov64),
    .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_illegal(il64)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel,
                                          input bit x64, output logic ill);
    logic [63:0] v;
    ill = 1'b0;
    case (sel)
      3'd0: v = {{52{ins[31]}}, ins[31:20]};
      3'd1: v = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      3'd2: v = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd3: v = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      3'd4: v = {{32{ins[31]}}, ins[31:12], 12'b0};
      3'd5: v = {59'b0, ins[19:15]};
      3'd6: begin
        v   = x64 ? {58'b0, ins[25:20]} : {59'b0, ins[24:20]};
        ill = !x64 && ins[25];
      end
      default: begin
        v   = '0;
        ill = 1'b1;
      end
    endcase
    return v;
  endfunction

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ov32, ov64, rdy32, rdy64} !== 4'b0011) begin
      n_fail++;
      $display("FAIL reset_handshake: got v/r %b want 0011", {ov32, ov64, rdy32, rdy64});
    end
    n_checks++;
    if (imm32 !== 32'h0 || imm64 !== 64'h0 || tag32 !== '0 || tag64 !== '0 || il32 || il64)
    begin
      n_fail++;
      $display("FAIL reset_data: got %h %h tag %h %h ill %b%b want zeros",
               imm32, imm64, tag32, tag64, il32, il64);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      in_instr  = v_instr[i];
      in_immsrc = 3'(i);
      in_tag    = TW'(i + 1);
      step();
      n_checks++;
      if (!ov32 || !ov64 || tag32 !== TW'(i + 1) || tag64 !== TW'(i + 1)) begin
        n_fail++;
        $display("FAIL stream_tag[%0d]: got v %b%b tag %0d/%0d want valid tag %0d",
                 i, ov32, ov64, tag32, tag64, i + 1);
      end
      n_checks++;
      if (imm32 !== v_e32[i] || il32 !== v_i32[i]) begin
        n_fail++;
        $display("FAIL stream_x32[%0d]: got %h ill %b want %h ill %b",
                 i, imm32, il32, v_e32[i], v_i32[i]);
      end
      n_checks++;
      if (imm64 !== v_e64[i] || il64 !== v_i64[i]) begin
        n_fail++;
        $display("FAIL stream_x64[%0d]: got %h ill %b want %h ill %b",
                 i, imm64, il64, v_e64[i], v_i64[i]);
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (ov32 || ov64) begin
      n_fail++;
      $display("FAIL stream_drain: got out_valid %b%b want 00", ov32, ov64);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = v_instr[0];
    in_immsrc = 3'd0;
    in_tag    = TW'(1);
    step();
    n_checks++;
    if (!ov32 || tag32 !== TW'(1) || !rdy32 || !rdy64) begin
      n_fail++;
      $display("FAIL bp_first: got v %b tag %0d rdy %b%b want 1 1 11", ov32, tag32, rdy32, rdy64);
    end
    in_instr  = v_instr[2];
    in_immsrc = 3'd2;
    in_tag    = TW'(2);
    step();
    n_checks++;
    if (!ov32 || tag32 !== TW'(1) || imm32 !== 32'hFFFFFFFF || rdy32 || rdy64) begin
      n_fail++;
      $display("FAIL bp_full: got v %b tag %0d imm %h rdy %b%b want 1 1 ffffffff 00",
               ov32, tag32, imm32, rdy32, rdy64);
    end
    in_instr  = v_instr[3];
    in_immsrc = 3'd3;
    in_tag    = TW'(3);
    step();
    n_checks++;
    if (!ov32 || tag32 !== TW'(1) || tag64 !== TW'(1) || rdy32) begin
      n_fail++;
      $display("FAIL bp_hold: got v %b tag %0d/%0d rdy %b want 1 1/1 0",
               ov32, tag32, tag64, rdy32);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (!ov32 || tag32 !== TW'(2) || imm32 !== 32'hFFFFFFFC || imm64 !== 64'hFFFFFFFFFFFFFFFC
        || !rdy32) begin
      n_fail++;
      $display("FAIL bp_release2: got v %b tag %0d imm %h/%h rdy %b want 1 2 fffffffc 1",
               ov32, tag32, imm32, imm64, rdy32);
    end
    step();
    n_checks++;
    if (!ov32 || tag32 !== TW'(3) || imm32 !== 32'h8 || !rdy32) begin
      n_fail++;
      $display("FAIL bp_release3: got v %b tag %0d imm %h rdy %b want 1 3 8 1",
               ov32, tag32, imm32, rdy32);
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (ov32 || ov64) begin
      n_fail++;
      $display("FAIL bp_empty: got out_valid %b%b want 00", ov32, ov64);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = v_instr[0];
    in_immsrc = 3'd0;
    in_tag    = TW'(4);
    step();
    in_tag = TW'(5);
    step();
    n_checks++;
    if (rdy32 || !ov32) begin
      n_fail++;
      $display("FAIL flush_pre_full: got rdy %b v %b want 0 1", rdy32, ov32);
    end
    flush  = 1'b1;
    in_tag = TW'(6);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (ov32 || ov64 || !rdy32 || !rdy64) begin
      n_fail++;
      $display("FAIL flush_full: got v %b%b rdy %b%b want 00 11", ov32, ov64, rdy32, rdy64);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (ov32 || ov64) begin
      n_fail++;
      $display("FAIL flush_full_ghost: got v %b%b tag %0d want 00", ov32, ov64, tag32);
    end
    in_valid = 1'b1;
    in_tag   = TW'(7);
    step();
    flush  = 1'b1;
    in_tag = TW'(8);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (ov32 || ov64) begin
      n_fail++;
      $display("FAIL flush_one: got v %b%b tag %0d want 00", ov32, ov64, tag32);
    end
    in_valid  = 1'b1;
    in_instr  = v_instr[2];
    in_immsrc = 3'd2;
    in_tag    = TW'(9);
    step();
    in_valid = 1'b0;
    n_checks++;
    if (!ov32 || tag32 !== TW'(9) || imm32 !== 32'hFFFFFFFC) begin
      n_fail++;
      $display("FAIL flush_after: got v %b tag %0d imm %h want 1 9 fffffffc", ov32, tag32, imm32);
    end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = v_instr[4];
    in_immsrc = 3'd4;
    in_tag    = TW'(10);
    step();
    in_valid = 1'b0;
    n_checks++;
    if (!ov32 || tag32 !== TW'(10) || imm64 !== 64'hFFFFFFFF80000000) begin
      n_fail++;
      $display("FAIL areset_pre: got v %b tag %0d imm %h want 1 10 ffffffff80000000",
               ov32, tag32, imm64);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (ov32 || ov64 || !rdy32 || !rdy64 || imm32 !== 32'h0 || imm64 !== 64'h0
        || tag32 !== '0 || tag64 !== '0 || il32 || il64) begin
      n_fail++;
      $display("FAIL areset_async: got v %b%b rdy %b%b imm %h/%h tag %0d want 00 11 0 0",
               ov32, ov64, rdy32, rdy64, imm32, imm64, tag32);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = v_instr[5];
    in_immsrc = 3'd5;
    in_tag    = TW'(11);
    step();
    in_valid = 1'b0;
    n_checks++;
    if (!ov32 || !ov64 || tag32 !== TW'(11) || imm32 !== 32'h1F || imm64 !== 64'h1F) begin
      n_fail++;
      $display("FAIL areset_after: got v %b%b tag %0d imm %h/%h want 11 11 1f",
               ov32, ov64, tag32, imm32, imm64);
    end
    step();
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e, held;
    bit stall_prev = 1'b0;
    int acc = 0;
    int cyc = 0;
    logic [63:0] r;
    logic l;
    while ((acc < N_BEATS || q.size() != 0) && cyc < CYC_LIMIT) begin
      in_valid  = (acc < N_BEATS) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_instr  = $urandom;
      in_immsrc = 3'($urandom_range(0, 7));
      in_tag    = TW'($urandom);
      @(negedge clk);
      n_checks++;
      if (ov32 !== (q.size() != 0) || ov64 !== (q.size() != 0) || rdy32 !== (q.size() < 2)
          || rdy64 !== (q.size() < 2)) begin
        n_fail++;
        $display("FAIL rand_occupancy@%0d: got v %b%b rdy %b%b want held %0d",
                 cyc, ov32, ov64, rdy32, rdy64, q.size());
      end
      if (stall_prev) begin
        n_checks++;
        if (imm32 !== held.i32 || il32 !== held.l32 || imm64 !== held.i64 || il64 !== held.l64
            || tag32 !== held.tag || tag64 !== held.tag) begin
          n_fail++;
          $display("FAIL rand_stall@%0d: got %h %h tag %0d want %h %h tag %0d",
                   cyc, imm32, imm64, tag32, held.i32, held.i64, held.tag);
        end
      end
      if (ov32 && out_ready && q.size() != 0) begin
        e = q.pop_front();
        n_checks++;
        if (imm32 !== e.i32 || il32 !== e.l32 || imm64 !== e.i64 || il64 !== e.l64
            || tag32 !== e.tag || tag64 !== e.tag) begin
          n_fail++;
          $display("FAIL rand_beat@%0d: got %h/%b %h/%b tag %0d want %h/%b %h/%b tag %0d",
                   cyc, imm32, il32, imm64, il64, tag32, e.i32, e.l32, e.i64, e.l64, e.tag);
        end
      end
      stall_prev = ov32 && !out_ready;
      held.i32 = imm32;
      held.l32 = il32;
      held.i64 = imm64;
      held.l64 = il64;
      held.tag = tag32;
      if (in_valid && rdy32) begin
        r = ref_imm(in_instr, in_immsrc, 1'b0, l);
        e.i32 = r[31:0];
        e.l32 = l;
        e.i64 = ref_imm(in_instr, in_immsrc, 1'b1, l);
        e.l64 = l;
        e.tag = in_tag;
        q.push_back(e);
        acc++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (acc != N_BEATS || q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_complete: got %0d accepted %0d pending want %0d accepted 0 pending",
               acc, q.size(), N_BEATS);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Registered, parametrised immediate generator for the pipelined RISC-V core's decode stage. Takes a 32-bit instruction word and an immediate-select code, and produces a sign- or zero-extended immediate of width XLEN. It adds CSR-uimm, shift-amount and illegal-select modes. The result sits behind a one-cycle registered stage with a valid/ready handshake, a 2-entry skid buffer and a flush, so decode can stall or squash without losing or duplicating instructions.

## Interface
- XLEN, default 32: immediate output width; legal values 32 and 64.
- TAG_W, default 5: width of the sideband tag (e.g. rd or ROB index) carried alongside each immediate.
- clk  input  1  rising-edge clock.
- reset_n  input  1  reset. One clock; reset is asynchronous and active-low.
- flush  input  1  squash all held entries; synchronous.
- in_valid  input  1  input beat present.
- in_ready  output  1  stage can accept a beat this cycle.
- in_instr  input  32  instruction word.
- in_immsrc  input  3  immediate-select code.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  output beat present.
- out_ready  input  1  consumer accepts the beat.
- out_imm  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag of the beat.
- out_illegal  output  1  the beat used an unsupported select code.

## Operation
- Immediate select, where s means sign-extend from Instr[31] to XLEN:
  - 000 I: s(Instr[31:20]).
  - 001 S: s({Instr[31:25], Instr[11:7]}).
  - 010 B: s({Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}).
  - 011 J: s({Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}).
  - 100 U: s({Instr[31:12], 12'b0}). For XLEN=64 the upper 32 bits replicate Instr[31].
  - 101 Z (CSR uimm): zero-extend Instr[19:15].
  - 110 SHAMT: zero-extend Instr[25:20] when XLEN=64. When XLEN=32, zero-extend Instr[24:20]; Instr[25]=1 is flagged illegal.
  - 111: out_imm=0, out_illegal=1.
  - out_illegal=0 in every other case.
- Storage: main register M and skid register K, each holding {valid, imm, tag, illegal}. Outputs are driven from M only.
- The input fires when in_valid & in_ready. The output fires when out_valid & out_ready.
- in_ready = ~K.valid. It comes straight from a register, with no combinational path from out_ready.
- States are derived from {M.valid, K.valid}: EMPTY (0,0), ONE (1,0), FULL (1,1). (0,1) is unreachable.
  - EMPTY: input fire loads M, giving ONE.
  - ONE, input fire with output fire: M is loaded with the new beat; stays ONE.
  - ONE, input fire only: K is loaded; goes to FULL.
  - ONE, output fire only: goes to EMPTY.
  - FULL: no input is accepted. Output fire copies K into M and goes to ONE.
- While out_valid=1 and out_ready=0, out_imm, out_tag and out_illegal hold stable.
- flush: on the next edge M.valid=0 and K.valid=0, regardless of the handshakes. An input presented in the flush cycle is dropped. An output fire in the flush cycle still counts as consumed.
- Beats leave in strict input order with no loss or duplication.

## Timing
- Latency: 1 cycle. A beat accepted at edge N is on the outputs after edge N.
- Throughput: 1 beat per cycle while out_ready=1.
- Reset (asynchronous assert, synchronous release): out_valid=0, in_ready=1, out_imm=0, out_tag=0, out_illegal=0, K cleared.
- Reset asserted mid-transfer discards M and K immediately.
- Data registers update only on a load, which keeps toggling low. After a flush their contents are don't-care, but out_valid must be 0.

## Test plan
- XLEN=32, streaming with out_ready=1:
  - 0xFFF00093/000 → 0xFFFFFFFF.
  - 0xFE000EE3/010 → 0xFFFFFFFC.
  - 0x0080006F/011 → 0x00000008.
  - 0x000FD073/101 → 0x0000001F.
  - One result per cycle, tags in order.
- XLEN=64:
  - 0x800000B7/100 → 0xFFFFFFFF80000000.
  - 0x03F01013/110 → 0x3F, illegal=0.
  - Under XLEN=32 the same instruction with 110 gives out_illegal=1.
  - Any instruction with 111 → imm 0, illegal=1.
- Backpressure: hold out_ready=0 and stream tags 1,2,3.
  - Tag 1 is held in M and tag 2 in K; in_ready falls after the second accept; tag 3 is not accepted.
  - Release out_ready: tags 1,2,3 emerge in order on consecutive cycles with in_ready back high.
- Flush in FULL with in_valid=1: next cycle out_valid=0 and in_ready=1; the flushed and concurrent beats never appear.
- Assert reset_n=0 mid-stream, asynchronously: out_valid drops without waiting for a clock edge and outputs go to zero. After release, the first new beat appears with 1-cycle latency.
- Random valid/ready stimulus over 10k beats, scoreboard against a reference model: no loss, no duplication, and outputs stable under stall.
